seg_scan_ctrl: RTL

Time-multiplexing scan controller for a bank of common-anode 7-segment digits that share one BCD-to-segment decoder. It holds a multi-digit BCD value in a shadow register and steps through the digits. For each digit it drives the decoder's 4-bit BCD input and asserts exactly one active-low digit enable. A blanking gap between digits prevents ghosting. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg_scan_ctrl_pkg.sv | 23 ++
 rtl/seg_scan_ctrl_if.sv | 31 +++
 rtl/seg_scan_ctrl_timer.sv | 42 ++++
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: blank code, scan
// state encoding and the one-cold digit-enable helper.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  // Active-low enable vector with only bit idx cleared; callers truncate to
  // their digit count.
  function automatic logic [MAX_DIGITS-1:0] digit_sel_n(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between a display owner (master) and the scan controller
// (slave), including a debug view of the scan state.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_pkg::*;

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // load is a single-cycle strobe with no back-pressure: the controller always
  // accepts it on the clk edge where load=1, and the newest strobe wins.
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] value_bcd;
  logic                    load;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_an_n;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;
  scan_state_t             state;

  modport master (
    output enable, value_bcd, load,
    input  bcd_out, digit_an_n, digit_idx, frame_done, state
  );

  modport slave (
    input  enable, value_bcd, load,
    output bcd_out, digit_an_n, digit_idx, frame_done, state
  );

endinterface

// File: rtl/seg_scan_ctrl_timer.sv
// Free-running period counter with a terminal-count flag; used for the
// per-digit blank+dwell period and reusable for other refresh timing.
module seg_scan_timer #(
  parameter int PERIOD = 10,
  parameter int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          run_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc_o    = run_i && (count_q == LAST);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i || !run_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Optional: define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zeros at commit.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int PERIOD = BLANK_CYCLES + DWELL_CYCLES;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW     = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic                  pvalid_q, pvalid_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q, fd_d;
  logic                  commit;
  logic [CW-1:0]         count;
  logic                  tc;

  // Value as it should appear in the shadow register once committed.
  function automatic logic [VW-1:0] commit_value(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (v[4*i +: 4] != 4'h0) seen = 1'b1;
        if (!seen) r[4*i +: 4] = BLANK_CODE;
      end
    end
`else
    r = v;
`endif
    return r;
  endfunction

  seg_scan_timer #(
    .PERIOD (PERIOD),
    .CW     (CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == IDLE),
    .run_i   (bus.enable),
    .count_o (count),
    .tc_o    (tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    pvalid_d  = pvalid_q;
    shadow_d  = shadow_q;
    fd_d      = 1'b0;
    commit    = 1'b0;
    an_d      = '1;
    bcd_d     = BLANK_CODE;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = BLANK;
          idx_d   = '0;
          commit  = 1'b1;
        end
      end
      BLANK: begin
        if (count == BLANK_LAST) state_d = DRIVE;
      end
      DRIVE: begin
        if (tc) begin
          state_d = BLANK;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            fd_d   = 1'b1;
            commit = pvalid_q;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
      fd_d    = 1'b0;
      commit  = 1'b0;
    end

    // Commit reads the old pending; a same-cycle load stays pending.
    if (commit) begin
      shadow_d = commit_value(pending_q);
      pvalid_d = 1'b0;
    end
    if (bus.load) begin
      pending_d = bus.value_bcd;
      pvalid_d  = 1'b1;
    end

    if (state_d == DRIVE) begin
      an_d  = NUM_DIGITS'(digit_sel_n(3'(idx_d)));
      bcd_d = shadow_q[4*idx_d +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= {NUM_DIGITS{BLANK_CODE}};
      pvalid_q  <= 1'b0;
      shadow_q  <= {NUM_DIGITS{BLANK_CODE}};
      bcd_q     <= BLANK_CODE;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      pvalid_q  <= pvalid_d;
      shadow_q  <= shadow_d;
      bcd_q     <= bcd_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.digit_an_n = an_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = fd_q;
  assign bus.state      = state_q;

endmodule
